// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared types and constants for the commit-trace path.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam int          REC_XLEN    = 64;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [31:0]         inst;
    logic                wen;
    logic [4:0]          rd;
    logic [REC_XLEN-1:0] wdata;
  } commit_rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (c_aw+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/commit_trace.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace
// Description : Buffers retired-instruction records for the DPI bridge and
//               halts after draining on ebreak.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace
  import npc_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          XLEN        = 64,
  parameter logic [31:0] EBREAK_INST = npc_pkg::EBREAK_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmt_valid_i,
  output logic            cmt_ready_o,
  input  logic [XLEN-1:0] cmt_pc_i,
  input  logic [31:0]     cmt_inst_i,
  input  logic            cmt_wen_i,
  input  logic [4:0]      cmt_rd_i,
  input  logic [XLEN-1:0] cmt_wdata_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [XLEN-1:0] trace_pc_o,
  output logic [31:0]     trace_inst_o,
  output logic            trace_wen_o,
  output logic [4:0]      trace_rd_o,
  output logic [XLEN-1:0] trace_wdata_o,
  output logic [31:0]     halt_flag_o,
  output logic            halted_o,
  output logic [63:0]     retire_cnt_o
);

  localparam int c_cw = $clog2(DEPTH) + 1;

  trace_state_e    r_state;
  logic [31:0]     r_halt_flag;
  logic            r_halted;
  logic [63:0]     r_retire_cnt;
  commit_rec_t     w_in_rec;
  commit_rec_t     w_head;
  logic            w_full;
  logic            w_empty;
  logic [c_cw-1:0] w_count;
  logic            w_push;
  logic            w_pop;

  // Gating with rst_n keeps the core stalled for the whole reset window.
  assign cmt_ready_o   = rst_n && (r_state == RUN) && !w_full;
  assign trace_valid_o = !w_empty && (r_state != HALT);
  assign w_push        = cmt_valid_i && cmt_ready_o;
  assign w_pop         = trace_valid_o && trace_ready_i;

  assign w_in_rec.pc    = REC_XLEN'(cmt_pc_i);
  assign w_in_rec.inst  = cmt_inst_i;
  assign w_in_rec.wen   = cmt_wen_i;
  assign w_in_rec.rd    = cmt_rd_i;
  assign w_in_rec.wdata = REC_XLEN'(cmt_wdata_i);

  sync_fifo #(
    .WIDTH ($bits(commit_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_in_rec),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    trace_pc_o    = '0;
    trace_inst_o  = '0;
    trace_wen_o   = 1'b0;
    trace_rd_o    = '0;
    trace_wdata_o = '0;
    if (trace_valid_o) begin
      trace_pc_o    = w_head.pc[XLEN-1:0];
      trace_inst_o  = w_head.inst;
      trace_wen_o   = w_head.wen && (w_head.rd != 5'd0);
      trace_rd_o    = w_head.rd;
      trace_wdata_o = w_head.wdata[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_halt_flag  <= 32'd0;
      r_halted     <= 1'b0;
      r_retire_cnt <= 64'd0;
    end else begin
      if (w_pop) r_retire_cnt <= r_retire_cnt + 64'd1;
      case (r_state)
        RUN: begin
          if (w_push && (cmt_inst_i == EBREAK_INST)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && (w_count == c_cw'(1))) begin
            r_state     <= HALT;
            r_halt_flag <= 32'd1;
            r_halted    <= 1'b1;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end

  assign halt_flag_o  = r_halt_flag;
  assign halted_o     = r_halted;
  assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace
// Description : Directed and random bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace;

  localparam int          DEPTH  = 4;
  localparam int          XLEN   = 64;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmt_valid_i;
  logic            cmt_ready_o;
  logic [XLEN-1:0] cmt_pc_i;
  logic [31:0]     cmt_inst_i;
  logic            cmt_wen_i;
  logic [4:0]      cmt_rd_i;
  logic [XLEN-1:0] cmt_wdata_i;
  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [XLEN-1:0] trace_pc_o;
  logic [31:0]     trace_inst_o;
  logic            trace_wen_o;
  logic [4:0]      trace_rd_o;
  logic [XLEN-1:0] trace_wdata_o;
  logic [31:0]     halt_flag_o;
  logic            halted_o;
  logic [63:0]     retire_cnt_o;

  always #5 clk = ~clk;

  commit_trace #(.DEPTH(DEPTH), .XLEN(XLEN), .EBREAK_INST(EBREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_valid_i(cmt_valid_i), .cmt_ready_o(cmt_ready_o),
    .cmt_pc_i(cmt_pc_i), .cmt_inst_i(cmt_inst_i), .cmt_wen_i(cmt_wen_i),
    .cmt_rd_i(cmt_rd_i), .cmt_wdata_i(cmt_wdata_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o),
    .trace_wen_o(trace_wen_o), .trace_rd_o(trace_rd_o),
    .trace_wdata_o(trace_wdata_o), .halt_flag_o(halt_flag_o),
    .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } rec_t;

  rec_t        q[$];
  bit          m_drain;
  bit          m_halt;
  logic [63:0] m_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return rst_n && !m_drain && !m_halt && (q.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && !m_halt;
  endfunction

  task automatic model_reset();
    q.delete();
    m_drain = 0;
    m_halt  = 0;
    m_cnt   = 64'd0;
  endtask

  task automatic check_outputs();
    rec_t h;
    bit   v;
    v = m_valid();
    h = '{pc: 64'd0, inst: 32'd0, wen: 1'b0, rd: 5'd0, wdata: 64'd0};
    if (v) begin
      h = q[0];
      h.wen = h.wen && (h.rd != 5'd0);
    end
    chk("cmt_ready", 64'(cmt_ready_o), 64'(m_ready()));
    chk("trace_valid", 64'(trace_valid_o), 64'(v));
    chk("trace_pc", trace_pc_o, h.pc);
    chk("trace_inst", 64'(trace_inst_o), 64'(h.inst));
    chk("trace_wen", 64'(trace_wen_o), 64'(h.wen));
    chk("trace_rd", 64'(trace_rd_o), 64'(h.rd));
    chk("trace_wdata", trace_wdata_o, h.wdata);
    chk("halt_flag", 64'(halt_flag_o), m_halt ? 64'd1 : 64'd0);
    chk("halted", 64'(halted_o), 64'(m_halt));
    chk("retire_cnt", retire_cnt_o, m_cnt);
  endtask

  // One cycle: drive after the edge, check mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                      input logic wen, input logic [4:0] rd, input logic [63:0] wd,
                      input logic tr);
    bit   pushed;
    bit   popped;
    rec_t r;
    cmt_valid_i   = v;
    cmt_pc_i      = pc;
    cmt_inst_i    = inst;
    cmt_wen_i     = wen;
    cmt_rd_i      = rd;
    cmt_wdata_i   = wd;
    trace_ready_i = tr;
    #4;
    check_outputs();
    pushed = v && m_ready();
    popped = tr && m_valid();
    r = '{pc: pc, inst: inst, wen: wen, rd: rd, wdata: wd};
    @(posedge clk);
    #1;
    if (popped) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 64'd1;
      if (m_drain && q.size() == 0) begin
        m_drain = 0;
        m_halt  = 1;
      end
    end
    if (pushed) begin
      q.push_back(r);
      if (inst == EBREAK) m_drain = 1;
    end
  endtask

  task automatic idle(input logic tr);
    step(1'b0, 64'd0, 32'd0, 1'b0, 5'd0, 64'd0, tr);
  endtask

  task automatic push_nop(input logic [63:0] pc, input logic tr);
    step(1'b1, pc, NOP, 1'b1, 5'd1, pc ^ 64'h55, tr);
  endtask

  // Reset asserted mid-cycle, checked while held, released away from edges.
  task automatic do_reset();
    rst_n       = 1'b0;
    cmt_valid_i = 1'b0;
    #2;
    model_reset();
    check_outputs();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cmt_valid_i = 0; cmt_pc_i = '0; cmt_inst_i = '0; cmt_wen_i = 0;
    cmt_rd_i = '0; cmt_wdata_i = '0; trace_ready_i = 0;
    model_reset();
    #2;
    check_outputs();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes with the bridge always ready.
    for (int i = 0; i < 3; i++) push_nop(64'h8000_0000 + 64'(4 * i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("basic_retire3", retire_cnt_o, 64'd3);

    // Fill to full with the bridge stalled, then drain in order.
    for (int i = 0; i < 6; i++) push_nop(64'h8000_0000 + 64'(4 * i), 1'b0);
    chk("full_ready_low", 64'(cmt_ready_o), 64'd0);
    chk("full_head_pc", trace_pc_o, 64'h8000_0000);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Simultaneous push and pop at occupancy 2.
    push_nop(64'h9000_0000, 1'b0);
    push_nop(64'h9000_0004, 1'b0);
    push_nop(64'h9000_0008, 1'b1);
    chk("pushpop_head_pc", trace_pc_o, 64'h9000_0004);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // rd==0 masks the write enable but keeps the data.
    step(1'b1, 64'h8000_0100, NOP, 1'b1, 5'd0, 64'hDEAD, 1'b0);
    chk("rd0_wen", 64'(trace_wen_o), 64'd0);
    chk("rd0_rd", 64'(trace_rd_o), 64'd0);
    chk("rd0_wdata", trace_wdata_o, 64'hDEAD);
    idle(1'b1);
    idle(1'b1);

    // Ebreak: drain with a toggling bridge, then stay halted.
    do_reset();
    push_nop(64'h8000_0000, 1'b1);
    push_nop(64'h8000_0004, 1'b0);
    step(1'b1, 64'h8000_0008, EBREAK, 1'b0, 5'd0, 64'd0, 1'b1);
    chk("ebreak_ready_low", 64'(cmt_ready_o), 64'd0);
    for (int i = 0; i < 6; i++) push_nop(64'h8000_0010, 1'(i % 2));
    chk("halt_flag_set", 64'(halt_flag_o), 64'd1);
    chk("halt_retire3", retire_cnt_o, 64'd3);
    for (int i = 0; i < 3; i++) push_nop(64'h8000_0020, 1'b1);

    // Reset in the middle of a drain.
    do_reset();
    push_nop(64'hA000_0000, 1'b0);
    push_nop(64'hA000_0004, 1'b0);
    step(1'b1, 64'hA000_0008, EBREAK, 1'b0, 5'd0, 64'd0, 1'b0);
    idle(1'b1);
    do_reset();
    chk("rst_mid_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_mid_halt", 64'(halt_flag_o), 64'd0);
    chk("rst_mid_retire", retire_cnt_o, 64'd0);
    chk("rst_mid_ready", 64'(cmt_ready_o), 64'd1);

    // Random traffic; ebreak is rare and a halt is cleared by reset.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] inst;
      logic [4:0]  rd;
      if (m_halt && ($urandom_range(0, 3) == 0)) do_reset();
      inst = ($urandom_range(0, 39) == 0) ? EBREAK : $urandom();
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      step(1'($urandom()), {$urandom(), $urandom()}, inst, 1'($urandom()), rd,
           {$urandom(), $urandom()}, 1'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_trace.md
Name: commit_trace

Overview:
- Retirement-side stage that sits directly upstream of the simulator DPI bridge.
- Accepts one retired-instruction record per cycle from the core's writeback/commit point and buffers it in a small FIFO.
- Presents records to the bridge over a valid/ready handshake.
- Detects ebreak, drains outstanding records, then raises the 32-bit halt flag the bridge forwards to the simulator.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 64, width of pc and writeback data.
- EBREAK_INST, 32'h00100073, instruction encoding that triggers halt.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmt_valid_i  input  1  core presents a retired instruction.
- cmt_ready_o  output  1  stage can accept; core stalls commit when 0.
- cmt_pc_i  input  XLEN  pc of the retired instruction.
- cmt_inst_i  input  32  raw instruction word.
- cmt_wen_i  input  1  instruction wrote a GPR.
- cmt_rd_i  input  5  destination register index.
- cmt_wdata_i  input  XLEN  value written.
- trace_valid_o  output  1  head record is valid.
- trace_ready_i  input  1  bridge consumes the head record.
- trace_pc_o  output  XLEN  head pc.
- trace_inst_o  output  32  head instruction.
- trace_wen_o  output  1  head write-enable; forced 0 when rd==0.
- trace_rd_o  output  5  head rd.
- trace_wdata_o  output  XLEN  head write data.
- halt_flag_o  output  32  0 while running; 32'd1 once halted; feeds the bridge flag input.
- halted_o  output  1  FSM is in HALT.
- retire_cnt_o  output  64  count of records popped.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; rd_ptr = wr_ptr = 0; count = 0.
  - state = RUN; retire_cnt_o = 0; halt_flag_o = 0; halted_o = 0.
  - cmt_ready_o = 0 while rst_n is low; trace_valid_o = 0.
- Push: cmt_valid_i && cmt_ready_o at an edge writes the record at wr_ptr; wr_ptr advances modulo DEPTH.
- Pop: trace_valid_o && trace_ready_i at an edge advances rd_ptr modulo DEPTH and increments retire_cnt_o. The counter wraps from 2^64-1 to 0.
- Occupancy:
  - count tracks push minus pop.
  - A simultaneous push and pop leaves count unchanged.
  - Both are legal at any occupancy where cmt_ready_o = 1.
- cmt_ready_o = (state==RUN) && (count != DEPTH). It is combinational, with no dependence on trace_ready_i.
- Full: cmt_ready_o = 0, so there is no push, even if a pop occurs in the same cycle.
- Empty: trace_valid_o = 0, and all trace_* data outputs are driven to 0.
- There is no bypass: a record becomes visible on trace_* exactly 1 cycle after its push.
- trace_* outputs are combinational reads of the head slot. They are stable while trace_valid_o && !trace_ready_i.
- rd==0 writes: trace_wen_o = 0 whenever the stored rd is 0, regardless of cmt_wen_i.
- FSM states: RUN, DRAIN, HALT.
  - RUN → DRAIN: on a push whose cmt_inst_i == EBREAK_INST. The ebreak record itself is buffered, and cmt_ready_o drops from the next cycle.
  - DRAIN → HALT: on the pop that empties the FIFO (count goes 1→0).
  - HALT: absorbing until reset. halt_flag_o = 32'd1 and halted_o = 1, both registered and asserted the cycle after entry. cmt_ready_o = 0 and trace_valid_o = 0.
- cmt_* inputs are ignored when cmt_ready_o = 0.
- An asynchronous reset in any state returns immediately to reset values, discarding buffered records.

Decomposition:
- Shared package npc_pkg holds:
  - EBREAK_INST;
  - the commit_rec_t typedef {pc, inst, wen, rd, wdata};
  - the state enum {RUN, DRAIN, HALT}.
- One sub-module, sync_fifo, is natural: parameterised width/depth, with push/pop/full/empty/count and asynchronous active-low reset.
- commit_trace instantiates sync_fifo with commit_rec_t and adds the FSM, rd==0 masking and the retire counter.

Test Plan:
- Reset release, trace_ready_i=1, three pushes (pc 0x80000000/04/08, inst 0x00000013) → trace_valid_o each following cycle with matching pc; retire_cnt_o=3; halt_flag_o=0.
- trace_ready_i=0, continuous cmt_valid_i → cmt_ready_o falls after exactly DEPTH=4 pushes. Raising trace_ready_i pops in order 0x80000000..0x8000000C, and cmt_ready_o returns 1 the cycle after the first pop.
- With count=2, push and pop in the same cycle → count stays 2, and head pc advances by one record.
- Push a record with rd=0, cmt_wen_i=1, wdata=0xDEAD → trace_wen_o=0, trace_rd_o=0, trace_wdata_o=0xDEAD.
- Push two normal records then 0x00100073, with trace_ready_i toggling 1/0 → cmt_ready_o=0 from the cycle after the ebreak push. HALT is entered after the third pop; halt_flag_o=1 the following cycle; retire_cnt_o=3; later cmt_valid_i is ignored.
- Assert rst_n low mid-DRAIN with two records buffered → trace_valid_o=0, halt_flag_o=0, retire_cnt_o=0 immediately; after release, cmt_ready_o=1 and the state is RUN.
